// File: rtl/vec_mem_unit_pkg.sv
// Shared definitions for the vector load/store unit: opcodes, default sizes
// and the FSM state encoding.
package vec_mem_unit_pkg;

    localparam int LANES_DEF  = 16;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    // Same encodings the vector ALU decodes.
    localparam logic [3:0] OP_VLD = 4'b0100;
    localparam logic [3:0] OP_VST = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LWAIT = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vec_mem_unit_if.sv
// Word-wide data-memory port between the load/store unit (master) and the
// memory (slave). Read data arrives the cycle after mem_re.
interface vec_mem_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/vec_lane_buf.sv
// Lane register file: bulk load of a whole vector, one indexed lane write
// for load capture, one indexed lane read for store drain.
module vec_lane_buf #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_en,
    input  logic [LANES*DATA_W-1:0] ld_vec,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_W-1:0]       rd_data,
    output logic [LANES*DATA_W-1:0] vec
);

    logic [DATA_W-1:0] lanes_q [LANES];
    logic [DATA_W-1:0] lanes_d [LANES];

    always_comb begin
        lanes_d = lanes_q;
        if (ld_en) begin
            for (int i = 0; i < LANES; i++) lanes_d[i] = ld_vec[i*DATA_W +: DATA_W];
        end
        if (wr_en) lanes_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    always_comb begin
        vec = '0;
        for (int i = 0; i < LANES; i++) vec[i*DATA_W +: DATA_W] = lanes_q[i];
    end

    assign rd_data = lanes_q[rd_idx];

endmodule

// File: rtl/vec_mem_unit.sv
// Sequential vector load/store unit: moves one LANES x DATA_W vector to or
// from word-wide memory, one lane per cycle, starting at a base address.
module vec_mem_unit
    import vec_mem_unit_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    // Request handshake: start is taken only while busy=0; while busy=1 the
    // request inputs are ignored (not queued). done pulses for one cycle and
    // a new start is accepted in the following cycle.
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*DATA_W-1:0] vec_in,
    output logic                    busy,
    output logic                    done,
    output logic [LANES*DATA_W-1:0] vec_out,
    vec_mem_unit_if.master          mem,
    output state_t                  state_dbg
);

    localparam int              CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [LANES*DATA_W-1:0] vec_out_q, vec_out_d;

    logic                    buf_ld, buf_wr;
    logic [CNT_W-1:0]        buf_wr_idx;
    logic [DATA_W-1:0]       buf_rd_data;
    logic [LANES*DATA_W-1:0] buf_vec;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        busy_d     = busy_q;
        done_d     = done_q;
        vec_out_d  = vec_out_q;
        buf_ld     = 1'b0;
        buf_wr     = 1'b0;
        buf_wr_idx = cnt_q - CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (start && (opcode == OP_VLD || opcode == OP_VST)) begin
                    state_d = (opcode == OP_VLD) ? ST_LOAD : ST_STORE;
                    base_d  = addr;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    buf_ld  = (opcode == OP_VST);
                end
            end
            ST_LOAD: begin
                // Read data lags the read by one cycle, so lane k-1 lands now.
                buf_wr = (cnt_q != '0);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LWAIT;
                end
            end
            ST_LWAIT: begin
                buf_wr     = 1'b1;
                buf_wr_idx = LAST;
                state_d    = ST_DONE;
                done_d     = 1'b1;
                // Last lane bypasses the buffer so vec_out switches in one step.
                vec_out_d  = buf_vec;
                vec_out_d[(LANES-1)*DATA_W +: DATA_W] = mem.mem_rdata;
            end
            ST_STORE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vec_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            vec_out_q <= vec_out_d;
        end
    end

    vec_lane_buf #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .IDX_W  (CNT_W)
    ) u_lane_buf (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (buf_ld),
        .ld_vec  (vec_in),
        .wr_en   (buf_wr),
        .wr_idx  (buf_wr_idx),
        .wr_data (mem.mem_rdata),
        .rd_idx  (cnt_q),
        .rd_data (buf_rd_data),
        .vec     (buf_vec)
    );

    // Memory strobes decode straight from state flops, so reset clears them at once.
    assign mem.mem_re    = (state_q == ST_LOAD);
    assign mem.mem_we    = (state_q == ST_STORE);
    assign mem.mem_addr  = (mem.mem_re || mem.mem_we) ? base_q + ADDR_W'(cnt_q) : '0;
    assign mem.mem_wdata = mem.mem_we ? buf_rd_data : '0;

    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_out   = vec_out_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench for vec_mem_unit: table of operations with expected done
// cycle and result vector, plus a mid-operation asynchronous reset sequence.
module tb_vec_mem_unit;
  import vec_mem_unit_pkg::*;

  typedef struct {
    logic [3:0]   op;
    logic [15:0]  addr;
    logic [255:0] vin;
    int           exp_done;   // cycle of the done pulse, 0 = no operation
    int           inj_a;      // cycles in which a VLD start is pulsed mid-op
    int           inj_b;
    logic [255:0] exp_vout;
  } vec_t;

  localparam int NCYC = 22;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   opcode;
  logic [15:0]  addr;
  logic [255:0] vec_in;
  logic         busy;
  logic         done;
  logic [255:0] vec_out;
  state_t       state_dbg;

  logic [15:0]  mem_model [65536];
  int           n_checks;
  int           n_fail;

  vec_mem_unit_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  vec_mem_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .vec_in    (vec_in),
    .busy      (busy),
    .done      (done),
    .vec_out   (vec_out),
    .mem       (mif.master),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: read data returned the cycle after mem_re
  always @(posedge clk) begin
    if (mif.mem_re) mif.mem_rdata <= mem_model[mif.mem_addr];
    if (mif.mem_we) mem_model[mif.mem_addr] <= mif.mem_wdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [255:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_re"},    mif.mem_re, 0);
    check({tag, "_we"},    mif.mem_we, 0);
    check({tag, "_addr"},  mif.mem_addr, 0);
    check({tag, "_wdata"}, mif.mem_wdata, 0);
    check({tag, "_vout"},  vec_out, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // driver + scoreboard for one operation; start accepted at end of cycle 0
  task automatic run_op(input string tag, input vec_t v);
    logic [15:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] exp_w;
    int          done_cnt;
    int          done_cyc;
    logic        exp_busy;
    done_cnt = 0;
    done_cyc = 0;
    if (v.op == OP_VLD)
      for (int i = 0; i < 16; i++) rd_q.push_back(v.addr + 16'(i));
    if (v.op == OP_VST)
      for (int i = 0; i < 16; i++) wr_q.push_back({v.addr + 16'(i), v.vin[i*16 +: 16]});
    @(negedge clk);
    start  = 1'b1;
    opcode = v.op;
    addr   = v.addr;
    vec_in = v.vin;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      exp_busy = (v.exp_done != 0) && (c <= v.exp_done);
      check({tag, "_busy"}, busy, exp_busy);
      check({tag, "_re_we_excl"}, mif.mem_re & mif.mem_we, 0);
      if (mif.mem_re) begin
        if (rd_q.size() == 0) fail_now({tag, "_rd_extra"}, mif.mem_addr);
        else check({tag, "_rd_addr"}, mif.mem_addr, rd_q.pop_front());
      end
      if (mif.mem_we) begin
        if (wr_q.size() == 0) fail_now({tag, "_wr_extra"}, {mif.mem_addr, mif.mem_wdata});
        else begin
          exp_w = wr_q.pop_front();
          check({tag, "_wr"}, {mif.mem_addr, mif.mem_wdata}, exp_w);
        end
      end else begin
        check({tag, "_wdata_idle"}, mif.mem_wdata, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == ((v.exp_done != 0) ? v.exp_done : NCYC))
        check({tag, "_vec_out"}, vec_out, v.exp_vout);
      // drive next-cycle inputs; request inputs are scrambled while busy
      start  = (c == v.inj_a || c == v.inj_b);
      opcode = (c == v.inj_a || c == v.inj_b) ? OP_VLD : v.op;
      addr   = ~v.addr;
      vec_in = ~v.vin;
    end
    start = 1'b0;
    check({tag, "_done_cnt"}, done_cnt, (v.exp_done != 0) ? 1 : 0);
    check({tag, "_done_cyc"}, done_cyc, v.exp_done);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
  endtask

  vec_t         tbl [7];
  logic [255:0] v_l1, v_a0, v_wrap, v_st2;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    opcode   = 4'h0;
    addr     = '0;
    vec_in   = '0;

    for (int a = 0; a < 65536; a++) mem_model[a] = 16'(a) ^ 16'h5A5A;
    for (int i = 0; i < 16; i++) mem_model[16 + i] = 16'h1000 + 16'(i);

    for (int i = 0; i < 16; i++) begin
      v_l1[i*16 +: 16]   = 16'h1000 + 16'(i);
      v_a0[i*16 +: 16]   = 16'hA0A0 ^ 16'(i);
      v_wrap[i*16 +: 16] = (16'hFFF8 + 16'(i)) ^ 16'h5A5A;
      v_st2[i*16 +: 16]  = 16'h3000 + 16'(i * 3);
    end

    tbl[0] = '{op:OP_VLD,  addr:16'h0010, vin:'0,    exp_done:18, inj_a:0, inj_b:0,  exp_vout:v_l1};
    tbl[1] = '{op:OP_VST,  addr:16'h0200, vin:v_a0,  exp_done:17, inj_a:0, inj_b:0,  exp_vout:v_l1};
    tbl[2] = '{op:OP_VLD,  addr:16'h0200, vin:'0,    exp_done:18, inj_a:0, inj_b:0,  exp_vout:v_a0};
    tbl[3] = '{op:OP_VLD,  addr:16'hFFF8, vin:'0,    exp_done:18, inj_a:0, inj_b:0,  exp_vout:v_wrap};
    tbl[4] = '{op:OP_VST,  addr:16'h0400, vin:v_st2, exp_done:17, inj_a:5, inj_b:10, exp_vout:v_wrap};
    tbl[5] = '{op:4'b0000, addr:16'h0010, vin:v_a0,  exp_done:0,  inj_a:0, inj_b:0,  exp_vout:v_wrap};
    tbl[6] = '{op:4'b0110, addr:16'h0020, vin:v_a0,  exp_done:0,  inj_a:0, inj_b:0,  exp_vout:v_wrap};

    repeat (3) @(negedge clk);
    check_reset_outs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_rel");

    for (int t = 0; t < 7; t++) begin
      run_op($sformatf("vec%0d", t), tbl[t]);
      @(negedge clk);
    end

    // asynchronous reset in cycle 8 of a load
    @(negedge clk);
    start  = 1'b1;
    opcode = OP_VLD;
    addr   = 16'h0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_rst_re_before", mif.mem_re, 1);
    check("mid_rst_addr_before", mif.mem_addr, 16'h0017);
    #2 rst = 1'b1;
    #1 check_reset_outs("mid_rst_async");
    repeat (2) @(negedge clk);
    check_reset_outs("mid_rst_held");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("post_rst_idle");

    run_op("after_rst", tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
# vec_mem_unit

Sequential vector load/store unit sitting directly downstream of the vector ALU. For VLD and VST, the ALU's address sum is presented here as the base address. The unit moves one 256-bit vector (16 lanes × 16 bits) to or from the 16-bit-wide data memory, one lane per cycle. Loads return the assembled vector for register writeback. Stores drain the supplied vector to memory.

## Interface
- LANES, 16, number of 16-bit lanes per vector
- DATA_W, 16, lane and memory word width
- ADDR_W, 16, memory word-address width
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request strobe, sampled only when busy=0
- opcode  input  4  0100 = VLD, 0101 = VST; any other value is ignored
- addr  input  ADDR_W  base word address (ALU result[15:0])
- vec_in  input  LANES*DATA_W  store data; lane i = bits [16i+15:16i]
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- vec_out  output  LANES*DATA_W  loaded vector, held until the next VLD completes
- mem_addr  output  ADDR_W  memory word address
- mem_re  output  1  memory read enable
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_re

## Operation
- States: IDLE, LOAD, LWAIT, STORE, DONE.
- IDLE, accepting a request:
  - start=1 with VLD: latch addr → LOAD.
  - start=1 with VST: latch addr and vec_in → STORE.
  - start=1 with any other opcode: no effect, stay IDLE.
- LOAD: lane counter k runs 0..15; mem_re=1 and mem_addr=base+k. Lane k-1 captures mem_rdata while k≥1. After k=15 → LWAIT.
- LWAIT: capture lane 15 → DONE.
- STORE: k runs 0..15; mem_we=1, mem_addr=base+k, mem_wdata=latched lane k. After k=15 → DONE.
- DONE: done=1 for one cycle → IDLE.
- Lane buffer vs. vec_out:
  - Loaded lanes accumulate in an internal buffer.
  - vec_out is updated from the buffer atomically on entry to DONE for VLD only.
  - VST never alters vec_out.
- Address arithmetic is modulo 2^ADDR_W. Base 16'hFFF8 accesses FFF8..FFFF, then 0000..0007.
- mem_re and mem_we are never high together. mem_wdata=0 whenever mem_we=0.
- start while busy=1 is ignored, not queued. vec_in and addr changes while busy have no effect.

## Timing
- Cycle 0 is the cycle in which start is accepted.
- VLD:
  - Reads issued in cycles 1-16.
  - Lane 15 captured at the end of cycle 17.
  - done and the new vec_out visible in cycle 18.
- VST: writes in cycles 1-16, done in cycle 17.
- busy is high from cycle 1 through the done cycle inclusive. A new start is accepted in the cycle after done.
- Reset values:
  - busy=0, done=0, mem_re=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, vec_out=0.
  - state=IDLE, counter=0.
- Reset mid-operation:
  - All outputs drop to reset values immediately, without waiting for clk.
  - A partial load never reaches vec_out.
  - A partial store leaves already-written words in memory; no further writes occur.

## Structure
- Shared package holds:
  - opcode constants VLD and VST (same encodings as the ALU)
  - LANES, DATA_W, ADDR_W defaults
  - state enum
- One sub-module, vec_lane_buf: a 16×16 register file with an indexed write port (load capture) and an indexed read port (store drain). It has async reset to 0.
- FSM, lane counter and address adder live in vec_mem_unit.

## Test plan
- VLD at addr 0x0010, with memory word at 0x0010+i = 0x1000+i → vec_out lane i = 0x1000+i. done pulses exactly in cycle 18. Exactly 16 mem_re cycles at 0x0010..0x001F.
- VST at addr 0x0200, vec_in lane i = 0xA0A0^i → 16 writes in cycles 1-16 at 0x0200..0x020F with matching data. done in cycle 17. vec_out is unchanged from its prior value.
- VLD at addr 0xFFF8 → addresses FFF8..FFFF then 0000..0007. Lanes are assembled in that order.
- start with VLD pulsed in cycles 5 and 10 of an in-flight VST → both ignored. Exactly one done. mem_re never asserts.
- start with opcode 0000 (VADD) → busy stays 0, no memory activity, no done.
- rst asserted asynchronously in cycle 8 of a VLD → all outputs 0 before the next clk edge. vec_out stays 0. A new VLD after reset completes normally in 18 cycles.
